seven_seg_scan_ctrl: RTL and testbench
======================================

# seven_seg_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It holds a packed hex value, steps through the digits at a fixed refresh rate and drives one digit at a time. Between digits it inserts an anti-ghosting blank gap. It sits between the core logic that produces a display value and the board's segment and anode pins, and performs the hex-to-segment decode internally using the team's standard active-low encoding.

## Interface
- DIGITS, 4: number of digits scanned; must be ≥ 2.
- DIV, 50000: clk cycles each digit is lit (SHOW phase); must be ≥ 1.
- BLANK, 16: clk cycles with all anodes off between digits (GAP phase); 0 removes the GAP phase.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  4*DIGITS  new display value; nibble i drives digit i, and digit 0 is the least significant.
- load  in  1  one-cycle strobe that captures `value` into the pending register.
- dp_mask  in  DIGITS  decimal point enable per digit, sampled live; 1 lights the point.
- lz_blank  in  1  leading-zero blanking enable, sampled live.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  DIGITS  digit anodes, active-low and one-hot-low while a digit is lit.
- pending  out  1  set when a loaded value is waiting for the next frame boundary.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- **Registers:**
  - disp_reg (4*DIGITS): the value currently shown.
  - pend_reg (4*DIGITS) with pending flag.
  - idx: 0..DIGITS-1.
  - phase: SHOW or GAP.
  - cnt: wide enough for max(DIV, BLANK).
- **FSM:**
  - SHOW: cnt counts 0..DIV-1. At DIV-1, cnt is cleared and the FSM goes to GAP, or straight to the next digit's SHOW if BLANK=0.
  - GAP: cnt counts 0..BLANK-1. At BLANK-1, cnt is cleared, idx advances and the FSM returns to SHOW.
- **idx wrap:** DIGITS-1 goes to 0. The cycle in which idx wraps is the frame boundary.
- **Frame boundary actions:**
  - frame_done pulses.
  - If pending=1, disp_reg is loaded from pend_reg and pending is cleared.
- **load:** writes pend_reg and sets pending.
  - A load in the boundary cycle writes pend_reg and leaves pending=1. The boundary copy uses the pre-load pend_reg, so the new value is shown from the following frame.
  - Back-to-back loads: the last one wins.
- **Decode:**
  - Nibble disp_reg[4*idx +: 4] maps to active-low segments, for example: 0 → 7'h40, 1 → 7'h79, 8 → 7'h00, F → 7'h0E.
- **Leading-zero blanking (lz_blank=1):**
  - Any digit above the most significant nonzero nibble gets seg=7'h7F, but its anode is still driven.
  - Digit 0 is never blanked.
  - dp still follows dp_mask.
- **GAP outputs:** an is all ones, seg=7'h7F, dp=1.
- **Arithmetic:** all comparisons are unsigned. cnt never exceeds DIV-1 in SHOW or BLANK-1 in GAP.

## Timing
- **Registered outputs:** seg, dp and an reflect phase/idx/cnt from the previous cycle, so there is one cycle of output latency.
- **Frame length:** DIGITS*(DIV+BLANK) cycles.
- **Reset values:**
  - Outputs: seg=7'h7F, dp=1, an all ones, pending=0, frame_done=0.
  - Internal: disp_reg=0, pend_reg=0, idx=0, phase=SHOW, cnt=0.
- **After reset release:** the first cycle shows digit 0 as "0", with an[0]=0 appearing one cycle after rst falls.
- **Reset mid-frame:** takes effect on the next edge and discards both disp_reg and pend_reg.
- **load during rst:** ignored.
- **frame_done:** asserted in the cycle after the boundary edge, aligned with an selecting digit 0.
- **pending:** rises the cycle after load and falls the cycle after the boundary that consumes it.
- **disp_reg update:** only at a frame boundary. Digits are never torn mid-frame.

## Test plan
All scenarios use DIGITS=4, DIV=4, BLANK=1.
- **Reset:** hold rst for 3 cycles, then release → seg=7'h7F, an=4'hF during reset. First lit pattern is an=4'hE, seg=7'h40. frame_done every 20 cycles.
- **Scan order:** load value=16'h1234 → the next frame shows an E/D/B/7 patterns with seg 7'h19 / 7'h30 / 7'h24 / 7'h79. Each digit lasts 4 cycles, separated by one cycle of an=4'hF.
- **Deferred update:** load 16'hABCD mid-frame → pending=1 until the boundary and the current frame is unchanged. From the next frame digit 0 shows 7'h21 (d).
- **Boundary collision:**
  - Setup: load 16'h1111, then issue load 16'h2222 exactly in the boundary cycle.
  - Frame N+1 shows 1111 and pending stays 1.
  - Frame N+2 shows 2222 and pending=0.
- **Leading zeros:** value=16'h0050 with lz_blank=1 → digits 3 and 2 give seg=7'h7F with their anodes active. Digit 1 shows 7'h12 and digit 0 shows 7'h40. value=0 shows only digit 0 as "0".
- **Mid-operation reset:** assert rst during digit 2 SHOW with pending=1 → the next cycle has an=4'hF and pending=0. After release, the display shows 0000.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display.
// Lights one digit at a time with a blank gap between digits; display updates only at frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000,
  parameter int unsigned BLANK  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  load_i,
  input  logic [DIGITS-1:0]     dp_mask_i,
  input  logic                  lz_blank_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  pending_o,
  output logic                  frame_done_o
);

  localparam int unsigned DW      = 4 * DIGITS;
  localparam int unsigned CNT_MAX = (DIV > BLANK) ? DIV : BLANK;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IDX_W   = $clog2(DIGITS);

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } phase_e;

  phase_e             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DW-1:0]      disp_q, disp_d;
  logic [DW-1:0]      pend_q, pend_d;
  logic               pending_q, pending_d;
  logic               wrap_q;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [DIGITS-1:0]  an_q, an_d;
  logic               frame_done_q;
  logic               boundary_c;
  logic [DIGITS-1:0]  lz_c;
  logic               zero_above;
  logic [3:0]         nib_c;

  // Standard active-low hex decode, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= SHOW;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pending_q    <= 1'b0;
      wrap_q       <= 1'b0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pending_q    <= pending_d;
      wrap_q       <= boundary_c;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= wrap_q;
    end
  end

  // Phase/digit sequencing; boundary_c marks the cycle where idx wraps to 0
  always_comb begin
    phase_d    = phase_q;
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    boundary_c = 1'b0;
    case (phase_q)
      SHOW: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          cnt_d = '0;
          if (BLANK == 0) begin
            if (idx_q == IDX_W'(DIGITS - 1)) begin
              idx_d      = '0;
              boundary_c = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            phase_d = GAP;
          end
        end
      end
      default: begin
        if (cnt_q == CNT_W'(BLANK - 1)) begin
          cnt_d   = '0;
          phase_d = SHOW;
          if (idx_q == IDX_W'(DIGITS - 1)) begin
            idx_d      = '0;
            boundary_c = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
    endcase
  end

  // Pending register; the boundary copy sees pend_q before any same-cycle load
  always_comb begin
    pend_d    = load_i ? value_i : pend_q;
    disp_d    = (boundary_c && pending_q) ? pend_q : disp_q;
    pending_d = pending_q;
    if (load_i) begin
      pending_d = 1'b1;
    end else if (boundary_c) begin
      pending_d = 1'b0;
    end
  end

  // lz_c[i] is set when digit i and every digit above it are zero
  always_comb begin
    lz_c       = '0;
    zero_above = 1'b1;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      zero_above = zero_above & (disp_q[4*i +: 4] == 4'h0);
      lz_c[i]    = zero_above;
    end
  end

  assign nib_c = disp_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = '1;
    if (phase_q == SHOW) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = (lz_blank_i && lz_c[idx_q]) ? 7'h7F : hex7(nib_c);
      dp_d  = ~dp_mask_i[idx_q];
    end
  end

  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign an_o         = an_q;
  assign pending_o    = pending_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with DIGITS=4, DIV=4, BLANK=1 (20-cycle frames).
// Frame position j counts samples from the frame_done sample: digit j/5 is lit unless j%5==4.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  dpm = 4'h0;
  logic        lz = 1'b0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        pending_o;
  logic        frame_done_o;

  int vectors = 0;
  int errors  = 0;

  seven_seg_scan_ctrl #(.DIGITS(4), .DIV(4), .BLANK(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .value_i      (value),
    .load_i       (load),
    .dp_mask_i    (dpm),
    .lz_blank_i   (lz),
    .seg_o        (seg_o),
    .dp_o         (dp_o),
    .an_o         (an_o),
    .pending_o    (pending_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Expected an/seg/dp at frame position j for a displayed value
  task automatic frame_exp(input int j, input logic [15:0] val, input logic lzb,
                           input logic [3:0] mask, output logic [3:0] ea,
                           output logic [6:0] es, output logic ed);
    int d;
    logic [15:0] sh;
    d = j / 5;
    if (j % 5 == 4) begin
      ea = 4'hF; es = 7'h7F; ed = 1'b1;
    end else begin
      ea = ~(4'b0001 << d);
      sh = val >> (4 * d);
      es = (lzb && d > 0 && sh == 16'h0000) ? 7'h7F : hex7(sh[3:0]);
      ed = ~mask[d];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // Advance to the next frame_done sample; n returns the number of cycles taken
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_done_o !== 1'b1 && n < 60);
    vectors++;
    if (frame_done_o !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame timeout frame_done=%b required 1", frame_done_o);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; value = 16'hFFFF; load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || pending_o !== 1'b0 || frame_done_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold an=%h seg=%h dp=%b pend=%b fd=%b required F/7f/1/0/0",
                 an_o, seg_o, dp_o, pending_o, frame_done_o);
      end
    end
    rst = 1'b0; load = 1'b0;
    step();
    vectors++;
    if (an_o !== 4'hE || seg_o !== 7'h40 || dp_o !== 1'b1 || pending_o !== 1'b0 || frame_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_digit an=%h seg=%h dp=%b pend=%b fd=%b required e/40/1/0/0",
               an_o, seg_o, dp_o, pending_o, frame_done_o);
    end
    for (int k = 0; k < 2; k++) begin
      wait_frame(n);
      vectors++;
      if (n != 20) begin
        errors++;
        $display("FAIL frame_period cycles=%0d required 20", n);
      end
    end
  endtask

  task automatic test_scan_order();
    int n; logic [3:0] ea; logic [6:0] es; logic ed;
    load_val(16'h1234);
    vectors++;
    if (pending_o !== 1'b1) begin
      errors++;
      $display("FAIL scan_pending_rise pending=%b required 1", pending_o);
    end
    wait_frame(n);
    for (int j = 0; j < 20; j++) begin
      if (j > 0) step();
      frame_exp(j, 16'h1234, 1'b0, 4'h0, ea, es, ed);
      vectors++;
      if (an_o !== ea || seg_o !== es || dp_o !== ed || frame_done_o !== (j == 0)) begin
        errors++;
        $display("FAIL scan_order j=%0d an=%h/%h seg=%h/%h dp=%b/%b fd=%b (actual/required)",
                 j, an_o, ea, seg_o, es, dp_o, ed, frame_done_o);
      end
    end
  endtask

  task automatic test_deferred();
    int n; logic [3:0] ea; logic [6:0] es; logic ed;
    wait_frame(n);
    for (int k = 0; k < 6; k++) step();
    load_val(16'hABCD);
    for (int j = 7; j < 20; j++) begin
      if (j > 7) step();
      frame_exp(j, 16'h1234, 1'b0, 4'h0, ea, es, ed);
      vectors++;
      if (an_o !== ea || seg_o !== es || pending_o !== (j < 19)) begin
        errors++;
        $display("FAIL deferred_old j=%0d an=%h/%h seg=%h/%h pend=%b (actual/required)",
                 j, an_o, ea, seg_o, es, pending_o);
      end
    end
    for (int j = 0; j < 20; j++) begin
      step();
      frame_exp(j, 16'hABCD, 1'b0, 4'h0, ea, es, ed);
      vectors++;
      if (an_o !== ea || seg_o !== es || pending_o !== 1'b0 || frame_done_o !== (j == 0)) begin
        errors++;
        $display("FAIL deferred_new j=%0d an=%h/%h seg=%h/%h pend=%b fd=%b (actual/required)",
                 j, an_o, ea, seg_o, es, pending_o, frame_done_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n; logic [3:0] ea; logic [6:0] es; logic ed;
    for (int k = 0; k < 3; k++) step();
    value = 16'h3333; load = 1'b1;
    step();
    value = 16'h4444;
    step();
    load = 1'b0;
    wait_frame(n);
    for (int j = 0; j < 20; j++) begin
      if (j > 0) step();
      frame_exp(j, 16'h4444, 1'b0, 4'h0, ea, es, ed);
      vectors++;
      if (an_o !== ea || seg_o !== es || pending_o !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back j=%0d an=%h/%h seg=%h/%h pend=%b (actual/required)",
                 j, an_o, ea, seg_o, es, pending_o);
      end
    end
  endtask

  task automatic test_collision();
    int n; logic [3:0] ea; logic [6:0] es; logic ed;
    wait_frame(n);
    for (int k = 0; k < 5; k++) step();
    load_val(16'h1111);
    for (int k = 0; k < 12; k++) step();
    value = 16'h2222; load = 1'b1;
    step();
    load = 1'b0;
    step();
    for (int j = 0; j < 20; j++) begin
      if (j > 0) step();
      frame_exp(j, 16'h1111, 1'b0, 4'h0, ea, es, ed);
      vectors++;
      if (an_o !== ea || seg_o !== es || pending_o !== (j < 19) || frame_done_o !== (j == 0)) begin
        errors++;
        $display("FAIL collision_n1 j=%0d an=%h/%h seg=%h/%h pend=%b fd=%b (actual/required)",
                 j, an_o, ea, seg_o, es, pending_o, frame_done_o);
      end
    end
    for (int j = 0; j < 20; j++) begin
      step();
      frame_exp(j, 16'h2222, 1'b0, 4'h0, ea, es, ed);
      vectors++;
      if (an_o !== ea || seg_o !== es || pending_o !== 1'b0 || frame_done_o !== (j == 0)) begin
        errors++;
        $display("FAIL collision_n2 j=%0d an=%h/%h seg=%h/%h pend=%b fd=%b (actual/required)",
                 j, an_o, ea, seg_o, es, pending_o, frame_done_o);
      end
    end
  endtask

  task automatic test_leading_zeros();
    int n; logic [3:0] ea; logic [6:0] es; logic ed;
    logic [15:0] vals [2];
    vals[0] = 16'h0050;
    vals[1] = 16'h0000;
    lz = 1'b1; dpm = 4'b1010;
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < 3; k++) step();
      load_val(vals[v]);
      wait_frame(n);
      for (int j = 0; j < 20; j++) begin
        if (j > 0) step();
        frame_exp(j, vals[v], 1'b1, 4'b1010, ea, es, ed);
        vectors++;
        if (an_o !== ea || seg_o !== es || dp_o !== ed) begin
          errors++;
          $display("FAIL leading_zero val=%h j=%0d an=%h/%h seg=%h/%h dp=%b/%b (actual/required)",
                   vals[v], j, an_o, ea, seg_o, es, dp_o, ed);
        end
      end
    end
    lz = 1'b0; dpm = 4'h0;
  endtask

  task automatic test_mid_reset();
    int n; logic [3:0] ea; logic [6:0] es; logic ed;
    for (int k = 0; k < 3; k++) step();
    load_val(16'h5678);
    wait_frame(n);
    step();
    load_val(16'h7777);
    for (int k = 0; k < 8; k++) step();
    vectors++;
    if (an_o !== 4'hB || seg_o !== 7'h02 || pending_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pre an=%h seg=%h pend=%b required b/02/1", an_o, seg_o, pending_o);
    end
    rst = 1'b1;
    step();
    vectors++;
    if (an_o !== 4'hF || seg_o !== 7'h7F || pending_o !== 1'b0 || frame_done_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_hit an=%h seg=%h pend=%b fd=%b required f/7f/0/0",
               an_o, seg_o, pending_o, frame_done_o);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (an_o !== 4'hE || seg_o !== 7'h40) begin
      errors++;
      $display("FAIL mid_reset_restart an=%h seg=%h required e/40", an_o, seg_o);
    end
    wait_frame(n);
    vectors++;
    if (n != 20) begin
      errors++;
      $display("FAIL mid_reset_period cycles=%0d required 20", n);
    end
    for (int j = 0; j < 20; j++) begin
      if (j > 0) step();
      frame_exp(j, 16'h0000, 1'b0, 4'h0, ea, es, ed);
      vectors++;
      if (an_o !== ea || seg_o !== es || pending_o !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_frame j=%0d an=%h/%h seg=%h/%h pend=%b (actual/required)",
                 j, an_o, ea, seg_o, es, pending_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_deferred();
    test_back_to_back();
    test_collision();
    test_leading_zeros();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
